// File: rtl/decode_execute_reg_if.sv
// Purpose: decode-side inputs and execute-side outputs of the D/E pipeline register.
// Latency: none (wiring only); the register module adds one cycle from D to E.
// Backpressure: none here; stall and flush travel as scalar ports on the register module.
interface decode_execute_reg_if #(parameter int W = 32);
  // Decode-stage fields
  logic         validD;
  logic         RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD;
  logic [1:0]   ALUControlD;
  logic [1:0]   FlagWriteD;
  logic [3:0]   CondD;
  logic [W-1:0] rd1D, rd2D, ExtImmD;
  logic [3:0]   ra1D, ra2D, wa3D;
  // Execute-stage copies
  logic         validE;
  logic         RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE;
  logic [1:0]   ALUControlE;
  logic [1:0]   FlagWriteE;
  logic [3:0]   CondE;
  logic [W-1:0] rd1E, rd2E, ExtImmE;
  logic [3:0]   ra1E, ra2E, wa3E;

  // Decode stage drives D fields and observes E fields
  modport master (
    output validD, RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD,
           ALUControlD, FlagWriteD, CondD, rd1D, rd2D, ExtImmD, ra1D, ra2D, wa3D,
    input  validE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE,
           ALUControlE, FlagWriteE, CondE, rd1E, rd2E, ExtImmE, ra1E, ra2E, wa3E
  );

  // Pipeline register consumes D fields and drives E fields
  modport slave (
    input  validD, RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD,
           ALUControlD, FlagWriteD, CondD, rd1D, rd2D, ExtImmD, ra1D, ra2D, wa3D,
    output validE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE,
           ALUControlE, FlagWriteE, CondE, rd1E, rd2E, ExtImmE, ra1E, ra2E, wa3E
  );
endinterface

// File: rtl/decode_execute_reg.sv
// Purpose: decode->execute pipeline register with bubble insertion and a saturating bubble counter.
// Latency: one cycle; every output comes straight from a flop.
// Backpressure: stallE holds E; any flush loads an all-zero bubble and overrides stallE.
module decode_execute_reg #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flushE,
  input  logic             branch_flushE,
  input  logic             stallE,
  input  logic             cnt_clr,
  decode_execute_reg_if.slave bus,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic         valid;
    logic         reg_write;
    logic         mem_write;
    logic         memto_reg;
    logic         branch;
    logic         alu_src;
    logic [1:0]   alu_control;
    logic [1:0]   flag_write;
    logic [3:0]   cond;
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic [W-1:0] ext_imm;
    logic [3:0]   ra1;
    logic [3:0]   ra2;
    logic [3:0]   wa3;
  } stage_t;

  stage_t           stage_d, stage_q, dec_in;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             bubble;

  assign bubble = flushE | branch_flushE;

  // Gather the decode fields into one record
  always_comb begin
    dec_in             = '0;
    dec_in.valid       = bus.validD;
    dec_in.reg_write   = bus.RegWriteD;
    dec_in.mem_write   = bus.MemWriteD;
    dec_in.memto_reg   = bus.MemtoRegD;
    dec_in.branch      = bus.BranchD;
    dec_in.alu_src     = bus.ALUSrcD;
    dec_in.alu_control = bus.ALUControlD;
    dec_in.flag_write  = bus.FlagWriteD;
    dec_in.cond        = bus.CondD;
    dec_in.rd1         = bus.rd1D;
    dec_in.rd2         = bus.rd2D;
    dec_in.ext_imm     = bus.ExtImmD;
    dec_in.ra1         = bus.ra1D;
    dec_in.ra2         = bus.ra2D;
    dec_in.wa3         = bus.wa3D;
  end

  // Next E contents: a zero bubble beats stall, stall beats load
  always_comb begin
    stage_d = stage_q;
    if (bubble) begin
      stage_d = '0;
    end else if (!stallE) begin
      stage_d = dec_in;
    end
  end

  // Bubble counter: clear wins, otherwise one count per flushing edge, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.validE      = stage_q.valid;
  assign bus.RegWriteE   = stage_q.reg_write;
  assign bus.MemWriteE   = stage_q.mem_write;
  assign bus.MemtoRegE   = stage_q.memto_reg;
  assign bus.BranchE     = stage_q.branch;
  assign bus.ALUSrcE     = stage_q.alu_src;
  assign bus.ALUControlE = stage_q.alu_control;
  assign bus.FlagWriteE  = stage_q.flag_write;
  assign bus.CondE       = stage_q.cond;
  assign bus.rd1E        = stage_q.rd1;
  assign bus.rd2E        = stage_q.rd2;
  assign bus.ExtImmE     = stage_q.ext_imm;
  assign bus.ra1E        = stage_q.ra1;
  assign bus.ra2E        = stage_q.ra2;
  assign bus.wa3E        = stage_q.wa3;
  assign bubble_cnt      = cnt_q;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Purpose: directed self-checking bench for decode_execute_reg with a narrow bubble counter.
// Latency: expects E outputs one edge after D inputs.
// Backpressure: exercises stall, flush, flush-over-stall and counter clear/saturation.
module tb_decode_execute_reg;
  localparam int W       = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid, reg_write, mem_write, memto_reg, branch, alu_src;
    logic [1:0]  alu_control, flag_write;
    logic [3:0]  cond;
    logic [31:0] rd1, rd2, ext_imm;
    logic [3:0]  ra1, ra2, wa3;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n, flushE, branch_flushE, stallE, cnt_clr;
  logic [CNT_W-1:0] bubble_cnt;
  rec_t d, e_act, exp_e;
  int   exp_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  logic running = 1'b0;

  decode_execute_reg_if #(.W(W)) bus ();

  decode_execute_reg #(.W(W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flushE       (flushE),
    .branch_flushE(branch_flushE),
    .stallE       (stallE),
    .cnt_clr      (cnt_clr),
    .bus          (bus),
    .bubble_cnt   (bubble_cnt)
  );

  always #5 clk = ~clk;

  assign bus.validD      = d.valid;
  assign bus.RegWriteD   = d.reg_write;
  assign bus.MemWriteD   = d.mem_write;
  assign bus.MemtoRegD   = d.memto_reg;
  assign bus.BranchD     = d.branch;
  assign bus.ALUSrcD     = d.alu_src;
  assign bus.ALUControlD = d.alu_control;
  assign bus.FlagWriteD  = d.flag_write;
  assign bus.CondD       = d.cond;
  assign bus.rd1D        = d.rd1;
  assign bus.rd2D        = d.rd2;
  assign bus.ExtImmD     = d.ext_imm;
  assign bus.ra1D        = d.ra1;
  assign bus.ra2D        = d.ra2;
  assign bus.wa3D        = d.wa3;

  assign e_act = {bus.validE, bus.RegWriteE, bus.MemWriteE, bus.MemtoRegE, bus.BranchE,
                  bus.ALUSrcE, bus.ALUControlE, bus.FlagWriteE, bus.CondE, bus.rd1E,
                  bus.rd2E, bus.ExtImmE, bus.ra1E, bus.ra2E, bus.wa3E};

  // Reference: E is either a zero bubble, the old contents, or the decode record
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_e   <= '0;
      exp_cnt <= 0;
    end else begin
      if (flushE || branch_flushE) exp_e <= '0;
      else if (!stallE)            exp_e <= d;
      if (cnt_clr)                         exp_cnt <= 0;
      else if (flushE || branch_flushE)    exp_cnt <= (exp_cnt + 1 > CNT_MAX) ? CNT_MAX : exp_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Cycle-by-cycle comparison against the reference, away from the rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (running && rst_n === 1'b1) begin
        check("model_e_bundle", e_act, exp_e);
        check("model_bubble_cnt", bubble_cnt, exp_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  rec_t pat_r, rec_a, rec_b, rec_c;

  initial begin
    pat_r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'h3, 2'h2, 4'hE,
              32'hDEADBEEF, 32'hCAFEF00D, 32'h00000FFF, 4'h1, 4'h2, 4'h3};
    rec_a = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'h1, 2'h1, 4'h0,
              32'hAAAA0001, 32'hAAAA0002, 32'h00000004, 4'h6, 4'h7, 4'h8};
    rec_b = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'h2, 2'h0, 4'h1,
              32'hBBBB0001, 32'hBBBB0002, 32'h00000010, 4'h9, 4'hA, 4'hB};
    rec_c = '0;
    rec_c.rd2 = 32'h0000C0DE;
    rec_c.ra1 = 4'hC;

    rst_n = 1'b0; flushE = 0; branch_flushE = 0; stallE = 0; cnt_clr = 0;
    d = pat_r;
    #1;
    check("reset_e_zero", e_act, 128'h0);
    check("reset_cnt_zero", bubble_cnt, 0);
    tick(); tick();
    #1 rst_n = 1'b1;
    running = 1'b1;

    // First edge after release loads D
    tick();
    check("post_reset_load", e_act, pat_r);
    flushE = 1; tick(); flushE = 0;
    check("flush_cnt_1", bubble_cnt, 1);
    tick();
    check("reload_pat", e_act, pat_r);

    // Asynchronous reset mid-cycle, no edge needed
    rst_n = 1'b0; #1;
    check("async_reset_e", e_act, 128'h0);
    check("async_reset_cnt", bubble_cnt, 0);
    #1 rst_n = 1'b1;
    tick();
    check("load_after_async", e_act, pat_r);

    // Plain load
    d = '0; d.valid = 1; d.reg_write = 1; d.rd1 = 32'h12345678; d.wa3 = 4'h5;
    tick();
    check("load_validE", bus.validE, 1);
    check("load_RegWriteE", bus.RegWriteE, 1);
    check("load_rd1E", bus.rd1E, 32'h12345678);
    check("load_wa3E", bus.wa3E, 5);
    check("load_cnt_hold", bubble_cnt, 0);

    // Load-use bubble
    d.memto_reg = 1; flushE = 1;
    tick(); flushE = 0;
    check("bubble_zero", e_act, 128'h0);
    check("bubble_cnt_1", bubble_cnt, 1);
    tick();
    check("after_bubble_MemtoRegE", bus.MemtoRegE, 1);
    check("after_bubble_rd1E", bus.rd1E, 32'h12345678);

    // Stall, with a flush arriving mid-stall
    d = rec_a; tick();
    d = rec_b; stallE = 1; tick();
    check("stall_hold_a", e_act, rec_a);
    flushE = 1; tick(); flushE = 0;
    check("flush_over_stall", e_act, 128'h0);
    check("flush_over_stall_cnt", bubble_cnt, 2);
    tick();
    check("stall_hold_bubble", e_act, 128'h0);
    stallE = 0; tick();
    check("release_load_b", e_act, rec_b);

    // Invalid decode slot loads as-is and is not a bubble
    d = rec_c; tick();
    check("invalid_load", e_act, rec_c);
    check("invalid_not_counted", bubble_cnt, 2);

    // Both flushes together count once; clear beats flush
    flushE = 1; branch_flushE = 1; tick();
    check("double_flush_cnt", bubble_cnt, 3);
    cnt_clr = 1; tick(); cnt_clr = 0;
    check("clear_wins_cnt", bubble_cnt, 0);
    check("clear_flush_e_zero", e_act, 128'h0);
    flushE = 0; tick();
    check("branch_flush_cnt", bubble_cnt, 1);
    branch_flushE = 0;

    // Saturation
    flushE = 1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt", bubble_cnt, 15);
    tick();
    check("sat_hold", bubble_cnt, 15);
    flushE = 0; cnt_clr = 1; tick(); cnt_clr = 0;
    check("sat_clear", bubble_cnt, 0);
    tick();

    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
